// File: rtl/ksa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : ksa_pkg                                                    |
// | Description : Shared types and helpers for the Kogge-Stone subtractor.   |
// |               pg_t carries one (generate, propagate) pair; pg_combine    |
// |               is the black-cell equation used at every prefix level.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ksa_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

   function automatic bit is_pow2(input int unsigned x);
      return (x != 0) && ((x & (x - 1)) == 0);
   endfunction

   // hi covers bit i, lo covers the span ending just below hi's span.
   function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
      pg_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_pg_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ksa_pg_cell                                                |
// | Description : Kogge-Stone black cell. Go = Gi | Pi&G_pre, Po = Pi&P_pre.  |
// | Ports       : i_gp     - (G,P) of the current bit                        |
// |               i_gp_pre - (G,P) of the bit one prefix distance below      |
// |               o_gp     - combined (G,P)                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ksa_pg_cell
   import ksa_pkg::*;
(
   input  pg_t i_gp,
   input  pg_t i_gp_pre,
   output pg_t o_gp
);

   assign o_gp = pg_combine(i_gp, i_gp_pre);

endmodule
`default_nettype wire

// File: rtl/ksa_sub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ksa_sub_pipe                                               |
// | Description : Pipelined Kogge-Stone subtractor, diff = a - b - bin,      |
// |               computed as a + ~b + ~bin. One register per prefix level,  |
// |               valid/ready on both sides, global stall enable.            |
// | Ports       : clk, rst_n (sync, active-low)                              |
// |               in_valid/in_ready, a, b, bin, in_tag   - operand side      |
// |               out_valid/out_ready, diff, borrow, zero, ovf, out_tag      |
// |                                                     - result side        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ksa_sub_pipe
   import ksa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int LEVELS = $clog2(WIDTH);

   if (!is_pow2(WIDTH) || (WIDTH < 8) || (WIDTH > 64)) begin : g_bad_width
      $error("ksa_sub_pipe: WIDTH must be a power of two in 8..64");
   end

   // ------------------------------------------------------------------
   // Pipeline storage: index 0 is the operand capture stage, index k
   // holds the result of prefix level k.
   // ------------------------------------------------------------------
   pg_t              r_pg   [LEVELS+1][WIDTH];
   pg_t              w_nxt  [LEVELS+1][WIDTH];
   logic [WIDTH-1:0] r_ppre [LEVELS+1];
   logic [TAG_W-1:0] r_tag  [LEVELS+1];
   logic [LEVELS:0]  r_vld;
   logic [LEVELS:0]  r_c0;
   logic [LEVELS:0]  r_amsb;
   logic [LEVELS:0]  r_bmsb;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_zero;
   logic             r_ovf;
   logic [TAG_W-1:0] r_out_tag;

   logic             w_adv;
   logic             w_c0;
   logic [WIDTH-1:0] w_bi;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_final_p_unused;
   logic             w_ovf_nxt;

   // Whole pipe advances together; bubbles keep their slot.
   assign w_adv    = ~r_out_valid | out_ready;
   assign in_ready = w_adv;

   assign w_bi = ~b;
   assign w_c0 = ~bin;
   assign w_p  = a ^ w_bi;

   // Stage 0: carry-in is folded into bit 0's generate, so every prefix
   // G[i] produced below already includes the P[i:0]&c0 term.
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage0
      if (i == 0) begin : g_lsb
         assign w_nxt[0][i] = '{g: (a[i] & w_bi[i]) | (w_p[i] & w_c0), p: w_p[i]};
      end else begin : g_upper
         assign w_nxt[0][i] = '{g: a[i] & w_bi[i], p: w_p[i]};
      end
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : g_level
      localparam int c_DIST = 1 << (k - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= c_DIST) begin : g_cell
            ksa_pg_cell u_cell (
               .i_gp     (r_pg[k-1][i]),
               .i_gp_pre (r_pg[k-1][i-c_DIST]),
               .o_gp     (w_nxt[k][i])
            );
         end else begin : g_pass
            assign w_nxt[k][i] = r_pg[k-1][i];
         end
      end
   end

   // After the last level, G[i] is the carry out of bit i.
   for (genvar i = 0; i < WIDTH; i++) begin : g_carry
      assign w_carry[i]          = r_pg[LEVELS][i].g;
      assign w_final_p_unused[i] = r_pg[LEVELS][i].p;
   end

   assign w_sum     = r_ppre[LEVELS] ^ {w_carry[WIDTH-2:0], r_c0[LEVELS]};
   assign w_ovf_nxt = (r_amsb[LEVELS] != r_bmsb[LEVELS]) &&
                      (w_sum[WIDTH-1] != r_amsb[LEVELS]);

   // Control and output registers (reset).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld       <= '0;
         r_out_valid <= 1'b0;
         r_diff      <= '0;
         r_borrow    <= 1'b0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_tag   <= '0;
      end else if (w_adv) begin
         r_vld       <= {r_vld[LEVELS-1:0], in_valid};
         r_out_valid <= r_vld[LEVELS];
         // Output data only changes when a real result arrives.
         if (r_vld[LEVELS]) begin
            r_diff    <= w_sum;
            r_borrow  <= ~w_carry[WIDTH-1];
            r_zero    <= (w_sum == '0);
            r_ovf     <= w_ovf_nxt;
            r_out_tag <= r_tag[LEVELS];
         end
      end
   end

   // Datapath registers: contents are don't-care while their valid is 0.
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_c0      <= {r_c0[LEVELS-1:0],   w_c0};
         r_amsb    <= {r_amsb[LEVELS-1:0], a[WIDTH-1]};
         r_bmsb    <= {r_bmsb[LEVELS-1:0], b[WIDTH-1]};
         r_ppre[0] <= w_p;
         r_tag[0]  <= in_tag;
         for (int k = 0; k <= LEVELS; k++) begin
            r_pg[k] <= w_nxt[k];
         end
         for (int k = 1; k <= LEVELS; k++) begin
            r_ppre[k] <= r_ppre[k-1];
            r_tag[k]  <= r_tag[k-1];
         end
      end
   end

   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign borrow    = r_borrow;
   assign zero      = r_zero;
   assign ovf       = r_ovf;
   assign out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_ksa_sub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ksa_sub_pipe                                            |
// | Description : Self-checking bench for ksa_sub_pipe (WIDTH=32, TAG_W=4).  |
// |               Directed vectors, back-pressure, reset mid-flight and a    |
// |               randomised scoreboard run.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ksa_sub_pipe;

   localparam int WIDTH = 32;
   localparam int TAG_W = 4;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             bin       = 1'b0;
   logic [TAG_W-1:0] in_tag    = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             zero;
   logic             ovf;
   logic [TAG_W-1:0] out_tag;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [32:0] bd;
      logic        z;
      logic        o;
      logic [3:0]  t;
   } exp_t;

   exp_t        exp_q[$];
   int          rx_cnt    = 0;
   bit          hold_pend = 1'b0;
   logic [38:0] held      = '0;

   always #5 clk = ~clk;

   ksa_sub_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .zero      (zero),
      .ovf       (ovf),
      .out_tag   (out_tag)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                  input logic ibin, input logic [3:0] it);
      exp_t e;
      e.bd = {1'b0, ia} - {1'b0, ib} - {32'd0, ibin};
      e.z  = (e.bd[31:0] == 32'd0);
      e.o  = (ia[31] != ib[31]) && (e.bd[31] != ia[31]);
      e.t  = it;
      return e;
   endfunction

   // One clock of streaming traffic: drive at negedge, inspect just after,
   // then let the rising edge commit whatever handshakes were seen.
   task automatic tick(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ibin, input logic [3:0] it, input logic ord,
                       output logic fired);
      exp_t e;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      bin       = ibin;
      in_tag    = it;
      out_ready = ord;
      #1;
      if (hold_pend) begin
         check("hold_valid", out_valid, 1'b1);
         check("hold_data", {borrow, diff, zero, ovf, out_tag}, held);
         hold_pend = 1'b0;
      end
      if (out_valid && !out_ready) begin
         check("stall_in_ready", in_ready, 1'b0);
         held      = {borrow, diff, zero, ovf, out_tag};
         hold_pend = 1'b1;
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            rx_cnt++;
            check("borrow_diff", {borrow, diff}, e.bd);
            check("zero", zero, e.z);
            check("ovf", ovf, e.o);
            check("tag", out_tag, e.t);
         end
      end
      fired = iv && in_ready;
      if (fired) exp_q.push_back(model(ia, ib, ibin, it));
      @(posedge clk);
   endtask

   // Single isolated operation with hand-computed expectations and a
   // latency count (the handshake edge is edge 1).
   task automatic directed(input string name, input logic [31:0] ia, input logic [31:0] ib,
                           input logic ibin, input logic [3:0] it,
                           input logic [32:0] ebd, input logic ez, input logic eo);
      int n;
      bit seen;
      @(negedge clk);
      in_valid  = 1'b1;
      a         = ia;
      b         = ib;
      bin       = ibin;
      in_tag    = it;
      out_ready = 1'b1;
      #1;
      check({name, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk);
      n    = 1;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      check({name, "_out_valid"}, out_valid, 1'b1);
      check({name, "_latency"}, n, 7);
      check({name, "_borrow_diff"}, {borrow, diff}, ebd);
      check({name, "_zero"}, zero, ez);
      check({name, "_ovf"}, ovf, eo);
      check({name, "_tag"}, out_tag, it);
   endtask

   initial begin
      #3000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          i;
      int          c;
      int          sent;
      logic        f;
      logic        pres;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rbin;
      logic [3:0]  rt;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_diff", diff, 32'd0);
      check("rst_borrow", borrow, 1'b0);
      check("rst_zero", zero, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_tag", out_tag, 4'd0);
      rst_n = 1'b1;

      // Directed arithmetic cases
      directed("basic",  32'd5,         32'd3,         1'b0, 4'd1, 33'h0_0000_0002, 1'b0, 1'b0);
      directed("borrow", 32'd3,         32'd5,         1'b0, 4'd2, 33'h1_FFFF_FFFE, 1'b0, 1'b0);
      directed("bin",    32'd0,         32'd0,         1'b1, 4'd3, 33'h1_FFFF_FFFF, 1'b0, 1'b0);
      directed("ovf",    32'h8000_0000, 32'd1,         1'b0, 4'd4, 33'h0_7FFF_FFFF, 1'b0, 1'b1);
      directed("equal",  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'd5, 33'h0_0000_0000, 1'b1, 1'b0);

      // Back-pressure: 10 back-to-back ops, out_ready low for 3 cycles
      exp_q.delete();
      rx_cnt = 0;
      i = 0;
      c = 0;
      while ((i < 10 || exp_q.size() > 0) && c < 200) begin
         tick(i < 10, 32'd1000 + i * 37, 32'd17 * i, i[0], i[3:0], !(c >= 9 && c < 12), f);
         if (f) i++;
         c++;
      end
      check("bp_count", rx_cnt, 10);
      check("bp_drain", exp_q.size(), 0);

      // Reset mid-flight
      i = 0;
      c = 0;
      while (i < 4 && c < 50) begin
         tick(1'b1, 32'd77 + i, 32'd5, 1'b0, 4'(i + 8), 1'b1, f);
         if (f) i++;
         c++;
      end
      check("mid_issue_count", i, 4);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_diff", diff, 32'd0);
      check("mid_rst_borrow", borrow, 1'b0);
      check("mid_rst_zero", zero, 1'b0);
      check("mid_rst_ovf", ovf, 1'b0);
      check("mid_rst_tag", out_tag, 4'd0);
      rst_n     = 1'b1;
      hold_pend = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_in_ready", in_ready, 1'b1);
      repeat (15) tick(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, f);

      // Random stream with random output stalls
      rx_cnt = 0;
      sent   = 0;
      c      = 0;
      pres   = 1'b0;
      ra     = '0;
      rb     = '0;
      rbin   = 1'b0;
      rt     = '0;
      while ((sent < 10000 || exp_q.size() > 0) && c < 60000) begin
         if (!pres && sent < 10000) begin
            pres = ($urandom_range(0, 4) != 0);
            if (pres) begin
               ra   = $urandom;
               rb   = ($urandom_range(0, 15) == 0) ? ra : $urandom;
               rbin = 1'($urandom_range(0, 1));
               rt   = 4'($urandom);
            end
         end
         tick(pres, ra, rb, rbin, rt, ($urandom_range(0, 3) != 0), f);
         if (f) begin
            pres = 1'b0;
            sent++;
         end
         c++;
      end
      check("rand_count", rx_cnt, 10000);
      check("rand_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
